// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - timer count register (TCNT) with edge-detected count strobe
//
// Purpose: counts rising edges of the divided clock int_clk (sampled as data on
// pclk), with load from TDR, up/down direction and sticky overflow/underflow flags.
//
// Ports:
//   pclk      system clock, sole clock of the block
//   preset    asynchronous active-high reset
//   int_clk   divided clock from the clock-select stage, used as a count strobe
//   en        count enable
//   up_down   count direction (1 = up, 0 = down), sampled when tick is high
//   load      single-cycle strobe, loads tdr into cnt (wins over a tick)
//   tdr       load value
//   clr_ovf   single-cycle clear of ovf_flag (a same-cycle set wins)
//   clr_udf   single-cycle clear of udf_flag (a same-cycle set wins)
//   cnt       current counter value
//   tick      registered count strobe, one pclk cycle per int_clk rising edge
//   ovf_flag  sticky overflow flag
//   udf_flag  sticky underflow flag
module timer_counter #(
  parameter int WIDTH = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             int_clk,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] tdr,
  input  logic             clr_ovf,
  input  logic             clr_udf,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic             ovf_flag,
  output logic             udf_flag
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic int_clk_d;
  logic count_up;
  logic count_dn;
  logic ovf_set;
  logic udf_set;

  // A pending load swallows the tick of the same cycle, so it also blocks the wrap flags.
  assign count_up = tick & ~load & up_down;
  assign count_dn = tick & ~load & ~up_down;
  assign ovf_set  = count_up & (cnt == ALL_ONES);
  assign udf_set  = count_dn & (cnt == ZERO);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      int_clk_d <= 1'b0;
      tick      <= 1'b0;
      cnt       <= ZERO;
      ovf_flag  <= 1'b0;
      udf_flag  <= 1'b0;
    end else begin
      // Edge history keeps tracking while disabled, so raising en while int_clk
      // is already high cannot create a spurious tick.
      int_clk_d <= int_clk;
      tick      <= int_clk & ~int_clk_d & en;

      if (load) begin
        cnt <= tdr;
      end else if (count_up) begin
        cnt <= cnt + ONE;
      end else if (count_dn) begin
        cnt <= cnt - ONE;
      end

      // Set has priority over a coincident clear.
      ovf_flag <= ovf_set | (ovf_flag & ~clr_ovf);
      udf_flag <= udf_set | (udf_flag & ~clr_udf);
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - scoreboard bench for timer_counter
module tb_timer_counter;

  logic       pclk;
  logic       preset;
  logic       int_clk;
  logic       en;
  logic       up_down;
  logic       load;
  logic [7:0] tdr;
  logic       clr_ovf;
  logic       clr_udf;
  logic [7:0] cnt;
  logic       tick;
  logic       ovf_flag;
  logic       udf_flag;

  timer_counter #(.WIDTH(8)) dut (
    .pclk(pclk),
    .preset(preset),
    .int_clk(int_clk),
    .en(en),
    .up_down(up_down),
    .load(load),
    .tdr(tdr),
    .clr_ovf(clr_ovf),
    .clr_udf(clr_udf),
    .cnt(cnt),
    .tick(tick),
    .ovf_flag(ovf_flag),
    .udf_flag(udf_flag)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tick;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: count value as a plain integer, wrapped with modulo.
  int m_cnt  = 0;
  bit m_tick = 0;
  bit m_prev = 0;
  bit m_ovf  = 0;
  bit m_udf  = 0;

  bit synced = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.cnt  = m_cnt[7:0];
    e.tick = m_tick;
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    exp_q.push_back(e);
  endtask

  // One pclk cycle: drive inputs, predict the state after the coming edge.
  task automatic step(input bit ic, input bit e, input bit ud, input bit ld,
                      input logic [7:0] d, input bit co, input bit cu);
    bit new_tick;
    bit wrap_o;
    bit wrap_u;
    if (synced) #1;
    else begin
      @(posedge pclk);
      #2;
    end
    synced  = 0;
    preset  = 1'b0;
    int_clk = ic;
    en      = e;
    up_down = ud;
    load    = ld;
    tdr     = d;
    clr_ovf = co;
    clr_udf = cu;

    new_tick = ic && !m_prev && e;
    m_prev   = ic;
    wrap_o   = 0;
    wrap_u   = 0;
    if (ld) begin
      m_cnt = int'(d);
    end else if (m_tick) begin
      if (ud) begin
        wrap_o = (m_cnt == 255);
        m_cnt  = (m_cnt + 1) % 256;
      end else begin
        wrap_u = (m_cnt == 0);
        m_cnt  = (m_cnt + 255) % 256;
      end
    end
    m_ovf  = wrap_o || (m_ovf && !co);
    m_udf  = wrap_u || (m_udf && !cu);
    m_tick = new_tick;
    push_model();
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    if (synced) #1;
    else begin
      @(posedge pclk);
      #2;
    end
    synced = 0;
    preset = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt), 32'h0);
    chk("async_rst_tick", 32'(tick), 32'h0);
    chk("async_rst_ovf", 32'(ovf_flag), 32'h0);
    chk("async_rst_udf", 32'(udf_flag), 32'h0);
    m_cnt  = 0;
    m_tick = 0;
    m_prev = 0;
    m_ovf  = 0;
    m_udf  = 0;
    push_model();
  endtask

  // Direct check of DUT state right after the edge predicted by the last step.
  task automatic check_now(input string name, input logic [31:0] got_sel, input logic [31:0] want);
    chk(name, got_sel, want);
  endtask

  task automatic sync_edge();
    @(posedge pclk);
    #1;
    synced = 1;
  endtask

  // Monitor: every edge the DUT presents a new state; compare it to the oldest prediction.
  initial begin
    exp_t e;
    bit prev_tick = 0;
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_cnt", 32'(cnt), 32'(e.cnt));
        chk("sb_tick", 32'(tick), 32'(e.tick));
        chk("sb_ovf", 32'(ovf_flag), 32'(e.ovf));
        chk("sb_udf", 32'(udf_flag), 32'(e.udf));
        chk("tick_back_to_back", 32'(tick && prev_tick), 32'h0);
        prev_tick = tick;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    preset  = 1'b1;
    int_clk = 1'b0;
    en      = 1'b0;
    up_down = 1'b0;
    load    = 1'b0;
    tdr     = 8'h00;
    clr_ovf = 1'b0;
    clr_udf = 1'b0;
    #3;
    chk("reset_cnt", 32'(cnt), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_ovf", 32'(ovf_flag), 32'h0);
    chk("reset_udf", 32'(udf_flag), 32'h0);

    // Up count at pclk/2: 10 rising edges of int_clk.
    for (int i = 0; i < 20; i++) step(i % 2 == 0, 1, 1, 0, 8'h00, 0, 0);
    sync_edge();
    check_now("up10_cnt", 32'(cnt), 32'h0A);

    // Overflow and clear.
    step(0, 1, 1, 1, 8'hFE, 0, 0);
    for (int i = 0; i < 4; i++) step(i % 2 == 0, 1, 1, 0, 8'h00, 0, 0);
    sync_edge();
    check_now("ovf_wrap_cnt", 32'(cnt), 32'h00);
    check_now("ovf_wrap_flag", 32'(ovf_flag), 32'h1);
    step(0, 1, 1, 0, 8'h00, 1, 0);
    sync_edge();
    check_now("ovf_cleared", 32'(ovf_flag), 32'h0);

    // Underflow, clear, then set/clear collision.
    step(0, 1, 0, 1, 8'h01, 0, 0);
    for (int i = 0; i < 4; i++) step(i % 2 == 0, 1, 0, 0, 8'h00, 0, 0);
    sync_edge();
    check_now("udf_wrap_cnt", 32'(cnt), 32'hFF);
    check_now("udf_wrap_flag", 32'(udf_flag), 32'h1);
    step(0, 1, 0, 0, 8'h00, 0, 1);
    sync_edge();
    check_now("udf_cleared", 32'(udf_flag), 32'h0);
    step(0, 1, 0, 1, 8'h01, 0, 0);
    step(1, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(1, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 0, 1);
    sync_edge();
    check_now("udf_collision_flag", 32'(udf_flag), 32'h1);
    check_now("udf_collision_cnt", 32'(cnt), 32'hFF);

    // Load in the same cycle as a tick.
    step(1, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 1, 1, 8'h80, 0, 0);
    sync_edge();
    check_now("load_vs_tick", 32'(cnt), 32'h80);

    // Enable gating with int_clk already high.
    step(0, 0, 1, 0, 8'h00, 0, 0);
    step(1, 0, 1, 0, 8'h00, 0, 0);
    step(1, 1, 1, 0, 8'h00, 0, 0);
    step(1, 1, 1, 0, 8'h00, 0, 0);
    sync_edge();
    check_now("en_gate_cnt", 32'(cnt), 32'h80);
    check_now("en_gate_tick", 32'(tick), 32'h0);
    step(0, 1, 1, 0, 8'h00, 0, 0);
    step(1, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 1, 0, 8'h00, 0, 0);
    sync_edge();
    check_now("en_gate_resume", 32'(cnt), 32'h81);

    // Reset mid-run with cnt=5A and ovf_flag=1.
    step(0, 1, 1, 1, 8'hFF, 0, 0);
    step(1, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 1, 1, 8'h5A, 0, 0);
    sync_edge();
    check_now("pre_rst_cnt", 32'(cnt), 32'h5A);
    check_now("pre_rst_ovf", 32'(ovf_flag), 32'h1);
    do_reset();

    // Randomized: int_clk from a random divider, random controls, rare resets.
    for (int blk = 0; blk < 24; blk++) begin
      int div;
      int ph;
      div = 2 << $urandom_range(0, 3);
      ph  = int'($urandom_range(0, 15));
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
        end else begin
          step(((ph + i) % div) >= (div / 2),
               $urandom_range(0, 9) != 0,
               blk % 3 == 0 ? 1'($urandom_range(0, 1)) : 1'(blk % 2),
               $urandom_range(0, 29) == 0,
               8'($urandom_range(0, 255)),
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0);
        end
      end
    end

    @(posedge pclk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
